// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: K ROM, rolling message schedule,
// UNROLL rounds per clock and the final chaining addition.
module sha256_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 &&
        UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
        $error("UNROLL must be 1, 2, 4, 8 or 16");
    end

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } hstate_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(
        input logic [31:0] x,
        input int          n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic hstate_t sha_round(
        input hstate_t     s,
        input logic [31:0] k,
        input logic [31:0] wt
    );
        hstate_t     r;
        logic [31:0] ch;
        logic [31:0] maj;
        logic [31:0] t1;
        logic [31:0] t2;
        ch  = (s.e & s.f) ^ (~s.e & s.g);
        maj = (s.a & s.b) ^ (s.a & s.c) ^ (s.b & s.c);
        t1  = s.h + bsig1(s.e) + ch + k + wt;
        t2  = bsig0(s.a) + maj;
        r.h = s.g;
        r.g = s.f;
        r.f = s.e;
        r.e = s.d + t1;
        r.d = s.c;
        r.c = s.b;
        r.b = s.a;
        r.a = t1 + t2;
        return r;
    endfunction

    function automatic hstate_t add_hash(
        input hstate_t x,
        input hstate_t y
    );
        hstate_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

    state_e      state;
    state_e      state_nx;
    hstate_t     cur;
    hstate_t     hv_save;
    hstate_t     hv_load;
    logic [31:0] w [16];
    logic [5:0]  rnd;
    logic        load;
    logic        step;
    logic        fin;

    logic [31:0] ext [16 + UNROLL];
    hstate_t     chain [UNROLL + 1];

    assign hv_load = init ? SHA_IV : hash_in;
    assign busy    = (state != IDLE);

    // ext[0] is always W[rnd]; the tail extends the window by UNROLL words
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = w[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] +
                          ssig0(ext[1 + j]) + ext[j];
        end
    end

    always_comb begin
        chain[0] = cur;
        for (int j = 0; j < UNROLL; j++) begin
            chain[j + 1] = sha_round(chain[j],
                                     K_ROM[rnd + 6'(j)],
                                     ext[j]);
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (rnd == LAST_RND) begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                fin      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= '0;
            hv_save  <= '0;
            w        <= '{default: '0};
            rnd      <= '0;
            done     <= 1'b0;
            hash_out <= '0;
        end else begin
            done <= fin;
            if (load) begin
                cur     <= hv_load;
                hv_save <= hv_load;
                rnd     <= '0;
                for (int i = 0; i < 16; i++) begin
                    w[i] <= block_in[511 - 32*i -: 32];
                end
            end else if (step) begin
                cur <= chain[UNROLL];
                rnd <= rnd + 6'(UNROLL);
                for (int i = 0; i < 16; i++) begin
                    w[i] <= ext[UNROLL + i];
                end
            end
            if (fin) begin
                hash_out <= add_hash(hv_save, cur);
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Scoreboard bench for sha256_round_engine across all legal UNROLL
// values: directed FIPS vectors, busy/reset corners, random blocks.
module tb_sha256_round_engine;

    localparam int ND = 5;
    localparam int UL [ND] = '{1, 2, 4, 8, 16};

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_H = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMP_H = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_H = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMP_B = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ND-1:0] start_v;
    logic [ND-1:0] init_v;
    logic [ND-1:0] busy_v;
    logic [ND-1:0] done_v;
    logic [511:0] blk_v [ND];
    logic [255:0] hin_v [ND];
    logic [255:0] hout_v [ND];

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        sha256_round_engine #(.UNROLL(UL[gi])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_v[gi]),
            .init     (init_v[gi]),
            .block_in (blk_v[gi]),
            .hash_in  (hin_v[gi]),
            .busy     (busy_v[gi]),
            .done     (done_v[gi]),
            .hash_out (hout_v[gi])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           dut;
        logic [255:0] hash;
        int           due;
    } exp_t;

    exp_t sbq [$];
    int n_run = 0;
    int n_fail = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x};
        return xx[n +: 32];
    endfunction

    function automatic logic [255:0] sha_ref(
        input logic [255:0] hv,
        input logic [511:0] b
    );
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation of that DUT
    logic [ND-1:0] done_prev = '0;
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (done_v[d] === 1'b1) begin
                int k;
                k = -1;
                for (int i = 0; i < sbq.size(); i++)
                    if (k < 0 && sbq[i].dut == d) k = i;
                check($sformatf("done_twice[U%0d]", UL[d]), 256'(done_prev[d]), 256'(0));
                if (k < 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_done[U%0d]: got done=1 want no done", UL[d]);
                end else begin
                    check($sformatf("hash[U%0d]", UL[d]), hout_v[d], sbq[k].hash);
                    check($sformatf("latency[U%0d]", UL[d]), 256'(cyc), 256'(sbq[k].due));
                    sbq.delete(k);
                end
            end
        end
        done_prev = done_v;
    end

    // done is expected after edge N+1, counting the accepting edge as 0
    task automatic arm(input int d, input logic ini, input logic [511:0] b,
                       input logic [255:0] hv, input logic [255:0] eh);
        exp_t e;
        start_v[d] = 1'b1;
        init_v[d] = ini;
        blk_v[d] = b;
        hin_v[d] = hv;
        e.dut = d;
        e.hash = eh;
        e.due = cyc + 2 + 64 / UL[d];
        sbq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        while (sbq.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout[U%0d]: got no done want hash %h", UL[sbq[0].dut], sbq[0].hash);
            void'(sbq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int d, input int budget, output bit ok);
        int t;
        t = 0;
        while (done_v[d] !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (done_v[d] === 1'b1);
        if (!ok) begin
            n_run++;
            n_fail++;
            $display("FAIL wait_done[U%0d]: got no done want done", UL[d]);
        end
    endtask

    task automatic chain_test(input int d);
        int d1;
        bit ok;
        arm(d, 1'b1, TWO_B1, 256'h0, sha_ref(IV, TWO_B1));
        @(negedge clk);
        start_v = '0;
        wait_done(d, 100, ok);
        if (ok) begin
            d1 = cyc;
            arm(d, 1'b0, TWO_B2, hout_v[d], TWO_H);
            @(negedge clk);
            start_v = '0;
            wait_done(d, 100, ok);
            // N+1 idle cycles separate the two pulses
            if (ok) check($sformatf("chain_gap[U%0d]", UL[d]), 256'(cyc - d1), 256'(64 / UL[d] + 2));
        end
        drain(100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] rb;
        logic [255:0] rh;
        logic [255:0] eh;
        start_v = '0;
        init_v = '0;
        for (int d = 0; d < ND; d++) begin
            blk_v[d] = '0;
            hin_v[d] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy_v), 256'(0));
        check("rst_done", 256'(done_v), 256'(0));
        check("rst_hash_u1", hout_v[0], 256'h0);
        check("rst_hash_u16", hout_v[4], 256'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" on UNROLL=1; hash_in must be ignored with init=1
        arm(0, 1'b1, ABC_B, {8{32'hdeadbeef}}, ABC_H);
        @(negedge clk);
        start_v = '0;
        check("busy_after_start", 256'(busy_v[0]), 256'(1));
        drain(100);

        // empty message on UNROLL=8
        arm(3, 1'b1, EMP_B, {8{32'h12345678}}, EMP_H);
        @(negedge clk);
        start_v = '0;
        drain(30);

        chain_test(0);
        chain_test(3);

        // start pulses while busy must be dropped
        arm(0, 1'b1, ABC_B, 256'h0, ABC_H);
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        init_v[0] = 1'b0;
        blk_v[0] = EMP_B;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        start_v[0] = 1'b1;
        init_v[0] = 1'b1;
        blk_v[0] = TWO_B1;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain(100);

        // asynchronous reset around round 30
        arm(0, 1'b1, ABC_B, 256'h0, ABC_H);
        @(negedge clk);
        start_v = '0;
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 256'(busy_v[0]), 256'(0));
        check("midrst_done", 256'(done_v[0]), 256'(0));
        check("midrst_hash", hout_v[0], 256'h0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        arm(0, 1'b1, ABC_B, 256'h0, ABC_H);
        @(negedge clk);
        start_v = '0;
        drain(100);

        // random blocks/chaining values, all UNROLL variants in parallel
        for (int it = 0; it < 100; it++) begin
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
            for (int i = 0; i < 8; i++) rh[32*i +: 32] = $urandom();
            eh = sha_ref(rh, rb);
            for (int d = 0; d < ND; d++) arm(d, 1'b0, rb, rh, eh);
            @(negedge clk);
            start_v = '0;
            drain(100);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
